// File: rtl/mul_hilo_pkg.sv
// ==========================================================================
// mul_hilo_pkg: shared types and constants for the HI/LO multiply unit.
// Rev 1.0
// ==========================================================================
`default_nettype none

package mul_hilo_pkg;

  localparam int WIDTH = 32;
  localparam int PROD_W = 2 * WIDTH;
  localparam logic [WIDTH-1:0] HILO_RST = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WB   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mul_hilo_unit_hilo_regs.sv
// ==========================================================================
// hilo_regs: HI/LO register pair; write-back of a product beats direct writes.
// Rev 1.0
// ==========================================================================
`default_nettype none

module hilo_regs
  import mul_hilo_pkg::*;
#(
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        wb_en,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hi_wr) hi_d = wr_data;
    if (lo_wr) lo_d = wr_data;
    if (wb_en) begin
      hi_d = wb_hi;
      lo_d = wb_lo;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      hi_q <= RST_VAL;
      lo_q <= RST_VAL;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

`default_nettype wire

// File: rtl/multiplier.sv
// ==========================================================================
// Multiplier: combinational 32x32 signed radix-4 Booth multiplier (64-bit).
// Rev 1.0
// ==========================================================================
`default_nettype none

module Multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] product
);

  logic [63:0] a_ext;
  logic [32:0] b_ext;
  logic [2:0]  trip;
  logic [63:0] pp;
  logic [63:0] acc;

  assign a_ext = {{32{a[31]}}, a};
  assign b_ext = {b, 1'b0};

  always_comb begin
    acc  = '0;
    trip = '0;
    pp   = '0;
    for (int i = 0; i < 16; i++) begin
      trip = b_ext[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2 * i));
    end
    product = acc;
  end

endmodule

`default_nettype wire

// File: rtl/mul_hilo_unit.sv
// ==========================================================================
// mul_hilo_unit: 3-state multiply controller feeding HI/LO.
// Optional unsigned mode (port is_unsigned) enabled by macro HILO_MULTU_EN.
// Rev 1.0
// ==========================================================================
`default_nettype none

module mul_hilo_unit #(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
`ifdef HILO_MULTU_EN
  input  logic        is_unsigned,
`endif
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  import mul_hilo_pkg::*;

  if (WIDTH != 32) begin : g_width_check
    $error("mul_hilo_unit: WIDTH must be 32 to match Multiplier");
  end

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] prod_q, prod_d;
  logic        done_q, done_d;
  logic [63:0] mult_p;
  logic [63:0] corr;

  Multiplier u_mult (
    .a       (a_q),
    .b       (b_q),
    .product (mult_p)
  );

`ifdef HILO_MULTU_EN
  logic uns_q, uns_d;

  // Signed-to-unsigned fixup: each negative operand lost 2^32 times the other.
  assign corr = uns_q ? ((a_q[31] ? {b_q, 32'h0} : 64'h0) +
                         (b_q[31] ? {a_q, 32'h0} : 64'h0)) : 64'h0;

  always_ff @(posedge clock) begin
    if (clear) uns_q <= 1'b0;
    else       uns_q <= uns_d;
  end

  always_comb begin
    uns_d = uns_q;
    if (state_q == IDLE && start) uns_d = is_unsigned;
  end
`else
  assign corr = 64'h0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        a_d     = op_a;
        b_d     = op_b;
        state_d = MUL;
      end
      MUL: begin
        prod_d  = mult_p + corr;
        state_d = WB;
      end
      WB: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  hilo_regs #(
    .RST_VAL (HILO_RST)
  ) u_hilo (
    .clock   (clock),
    .clear   (clear),
    .wb_en   (state_q == WB),
    .wb_hi   (prod_q[63:32]),
    .wb_lo   (prod_q[31:0]),
    .hi_wr   (hi_wr),
    .lo_wr   (lo_wr),
    .wr_data (wr_data),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  assign busy = (state_q == MUL) || (state_q == WB);
  assign done = done_q;

endmodule

`default_nettype wire
